// File: rtl/idli_qspi_mem_model.sv
// Multi-device quad-SPI SRAM model: decodes nibble-wide command/address/data bursts per chip select.
// Define IDLI_QMEM_MODE_EN to add per-device access modes (byte/page/sequential) and commands 0x01/0x05.
module idli_qspi_mem_model #(
   parameter int NUM_DEV   = 2,
   parameter int MEM_AW    = 16,
   parameter int ADDR_NIB  = 6,
   parameter int DUMMY_NIB = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_DEV-1:0] cs_n,
   input  logic [3:0]         sio_in,
   output logic [3:0]         sio_out,
   output logic [3:0]         sio_oe,
   output logic               err
);
   localparam int DEV_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
   localparam int CNT_W = $clog2(NUM_DEV + 1);
   localparam int DEPTH = NUM_DEV * (2 ** MEM_AW);

   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_SEQ  = 2'b01;
   localparam logic [1:0] MODE_PAGE = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_MODE, S_MRD, S_SKIP
   } state_t;

   state_t            state, state_nxt;
   logic [DEV_W-1:0]  dev, sel_idx;
   logic [CNT_W-1:0]  low_cnt;
   logic              active, multi;
   logic [3:0]        cmd_hi, hi_nib;
   logic [7:0]        cmd;
   logic [MEM_AW-1:0] addr, addr_shift, addr_rd;
   logic [7:0]        cnt;
   logic              is_read, phase, addr_last, dummy_last;
   logic [1:0]        mode_cur;
   logic [7:0]        rd_byte;
   logic [3:0]        out_nxt, oe_nxt;
   logic [7:0]        mem [DEPTH];

   function automatic logic [MEM_AW-1:0] bump(input logic [MEM_AW-1:0] a, input logic [1:0] m);
      if (m == MODE_PAGE) return {a[MEM_AW-1:5], a[4:0] + 5'd1};
      return a + MEM_AW'(1);
   endfunction

   // Only address bits below MEM_AW are kept; higher bus nibbles shift out and are ignored.
   assign cmd        = {cmd_hi, sio_in};
   assign addr_shift = {addr[MEM_AW-5:0], sio_in};
   assign addr_last  = (cnt == 8'(ADDR_NIB - 1));
   assign dummy_last = (cnt == 8'(DUMMY_NIB - 1));
   assign addr_rd    = (state == S_ADDR) ? addr_shift : addr;
   assign rd_byte    = mem[{dev, addr_rd}];

   always_comb begin
      low_cnt = '0;
      sel_idx = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (!cs_n[i]) begin
            low_cnt = low_cnt + CNT_W'(1);
            sel_idx = DEV_W'(i);
         end
      end
   end

   assign active = (low_cnt == CNT_W'(1));
   assign multi  = (low_cnt > CNT_W'(1));

`ifdef IDLI_QMEM_MODE_EN
   logic [1:0] mode [NUM_DEV];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_DEV; i++) mode[i] <= MODE_SEQ;
      end else if (active && state == S_MODE && phase && hi_nib[3:2] != 2'b11) begin
         mode[dev] <= hi_nib[3:2];
      end
   end

   assign mode_cur = mode[dev];
`else
   assign mode_cur = MODE_SEQ;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!active) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_CMD;
            S_CMD: begin
               case (cmd)
                  8'h02, 8'h03: state_nxt = S_ADDR;
`ifdef IDLI_QMEM_MODE_EN
                  8'h01:        state_nxt = S_MODE;
                  8'h05:        state_nxt = S_MRD;
`endif
                  default:      state_nxt = S_SKIP;
               endcase
            end
            S_ADDR:  if (addr_last) state_nxt = (is_read && DUMMY_NIB > 0) ? S_DUMMY : S_DATA;
            S_DUMMY: if (dummy_last) state_nxt = S_DATA;
            S_DATA:  if (phase && mode_cur == MODE_BYTE) state_nxt = S_SKIP;
            S_MODE:  if (phase) state_nxt = S_SKIP;
            S_MRD:   state_nxt = S_SKIP;
            default: state_nxt = S_SKIP;
         endcase
      end
   end

   // Next values of the registered pins; the bus is only driven while a read is streaming.
   always_comb begin
      out_nxt = 4'h0;
      oe_nxt  = 4'h0;
      if (active) begin
         case (state)
            S_ADDR: begin
               if (addr_last && is_read && DUMMY_NIB == 0) begin
                  out_nxt = rd_byte[7:4];
                  oe_nxt  = 4'hF;
               end
            end
            S_DUMMY: begin
               if (dummy_last) begin
                  out_nxt = rd_byte[7:4];
                  oe_nxt  = 4'hF;
               end
            end
            S_DATA: begin
               if (is_read) begin
                  out_nxt = phase ? rd_byte[3:0] : rd_byte[7:4];
                  oe_nxt  = 4'hF;
               end
            end
`ifdef IDLI_QMEM_MODE_EN
            S_CMD: begin
               if (cmd == 8'h05) begin
                  out_nxt = {mode_cur, 2'b00};
                  oe_nxt  = 4'hF;
               end
            end
            S_MRD: begin
               out_nxt = 4'h0;
               oe_nxt  = 4'hF;
            end
`endif
            default: ;
         endcase
      end
   end

   // phase: in DATA, set once the high nibble of the current byte has been handled.
   always_ff @(posedge clk) begin
      if (rst) begin
         sio_out <= 4'h0;
         sio_oe  <= 4'h0;
         err     <= 1'b0;
         dev     <= '0;
         cmd_hi  <= 4'h0;
         hi_nib  <= 4'h0;
         addr    <= '0;
         cnt     <= 8'd0;
         is_read <= 1'b0;
         phase   <= 1'b0;
      end else begin
         sio_out <= out_nxt;
         sio_oe  <= oe_nxt;
         if (multi) err <= 1'b1;
         if (active) begin
            case (state)
               S_IDLE: begin
                  dev    <= sel_idx;
                  cmd_hi <= sio_in;
               end
               S_CMD: begin
                  cnt     <= 8'd0;
                  phase   <= 1'b0;
                  is_read <= (cmd == 8'h03);
                  if (state_nxt == S_SKIP) err <= 1'b1;
               end
               S_ADDR: begin
                  addr  <= addr_shift;
                  cnt   <= addr_last ? 8'd0 : cnt + 8'd1;
                  phase <= is_read;
               end
               S_DUMMY: cnt <= cnt + 8'd1;
               S_DATA: begin
                  phase <= ~phase;
                  if (!phase) hi_nib <= sio_in;
                  else        addr   <= bump(addr, mode_cur);
               end
`ifdef IDLI_QMEM_MODE_EN
               S_MODE: begin
                  phase <= ~phase;
                  if (!phase)                     hi_nib <= sio_in;
                  else if (hi_nib[3:2] == 2'b11)  err    <= 1'b1;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && active && state == S_DATA && !is_read && phase) begin
         mem[{dev, addr}] <= {hi_nib, sio_in};
      end
   end

endmodule

// File: tb/tb_idli_qspi_mem_model.sv
// Scoreboard bench for idli_qspi_mem_model: random bursts against an array-based memory model.
module tb_idli_qspi_mem_model;
   localparam int NUM_DEV   = 2;
   localparam int MEM_AW    = 16;
   localparam int ADDR_NIB  = 6;
   localparam int DUMMY_NIB = 2;
   localparam int MEM_SIZE  = 2 ** MEM_AW;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_DEV-1:0] cs_n;
   logic [3:0]         sio_in;
   logic [3:0]         sio_out;
   logic [3:0]         sio_oe;
   logic               err;

   typedef struct {
      logic [3:0] nib;
      int         cyc;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] ref_mem [int];
   int         ref_mode [NUM_DEV];
   bit         ref_err;
   logic [7:0] wdata[$];
   int         cyc    = 0;
   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   idli_qspi_mem_model #(
      .NUM_DEV  (NUM_DEV),
      .MEM_AW   (MEM_AW),
      .ADDR_NIB (ADDR_NIB),
      .DUMMY_NIB(DUMMY_NIB)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .cs_n   (cs_n),
      .sio_in (sio_in),
      .sio_out(sio_out),
      .sio_oe (sio_oe),
      .err    (err)
   );

   // Monitor: every driven nibble must match the oldest expectation, in the predicted cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (sio_oe != 4'h0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_drive: cycle %0d sio_oe=0x%0h sio_out=0x%0h, required no drive",
                        cyc, sio_oe, sio_out);
            end else begin
               mon_e = exp_q.pop_front();
               if (sio_oe != 4'hF || sio_out != mon_e.nib || cyc != mon_e.cyc) begin
                  errors++;
                  $display("[TB] FAIL read_nibble: got out=0x%0h oe=0x%0h at cycle %0d, required out=0x%0h oe=0xf at cycle %0d",
                           sio_out, sio_oe, cyc, mon_e.nib, mon_e.cyc);
               end
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            errors++;
            mon_e = exp_q.pop_front();
            $display("[TB] FAIL missing_drive: no drive at cycle %0d, required out=0x%0h at cycle %0d",
                     cyc, mon_e.nib, mon_e.cyc);
         end
      end
   end

   function automatic int next_addr(input int dev, input int a);
      if (ref_mode[dev] == 2) return (a & ~31) | ((a + 1) & 31);
      return (a + 1) % MEM_SIZE;
   endfunction

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   task automatic drive_nib(input logic [3:0] n);
      sio_in = n;
      @(posedge clk);
      #1;
   endtask

   task automatic select_dev(input int dev);
      cs_n      = '1;
      cs_n[dev] = 1'b0;
   endtask

   task automatic deselect();
      cs_n   = '1;
      sio_in = 4'h0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_header(input int dev, input logic [7:0] cmd, input logic [23:0] addr);
      select_dev(dev);
      drive_nib(cmd[7:4]);
      drive_nib(cmd[3:0]);
      for (int i = ADDR_NIB - 1; i >= 0; i--) drive_nib(addr[4*i +: 4]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst     = 1'b0;
      ref_err = 1'b0;
      for (int d = 0; d < NUM_DEV; d++) ref_mode[d] = 1;
   endtask

   // Writes the bytes in wdata as one burst and records what the device should now hold.
   task automatic apply_stimulus(input int dev, input logic [23:0] addr);
      int a;
      a = int'(addr[MEM_AW-1:0]);
      send_header(dev, 8'h02, addr);
      foreach (wdata[i]) begin
         drive_nib(wdata[i][7:4]);
         drive_nib(wdata[i][3:0]);
         if (!(ref_mode[dev] == 0 && i > 0)) begin
            ref_mem[dev * MEM_SIZE + a] = wdata[i];
            a = next_addr(dev, a);
         end
      end
      deselect();
   endtask

   task automatic push_read(input int dev, input int a0, input int n, input int base);
      int         a;
      int         nexp;
      logic [7:0] b;
      a    = a0;
      nexp = (ref_mode[dev] == 0) ? 1 : n;
      for (int i = 0; i < nexp; i++) begin
         b = ref_mem[dev * MEM_SIZE + a];
         exp_q.push_back('{nib: b[7:4], cyc: base + 2 * i});
         exp_q.push_back('{nib: b[3:0], cyc: base + 2 * i + 1});
         a = next_addr(dev, a);
      end
   endtask

   task automatic read_burst(input int dev, input logic [23:0] addr, input int n);
      select_dev(dev);
      drive_nib(4'h0);
      drive_nib(4'h3);
      for (int i = ADDR_NIB - 1; i >= 0; i--) begin
         sio_in = addr[4*i +: 4];
         if (i == 0 && DUMMY_NIB == 0) push_read(dev, int'(addr[MEM_AW-1:0]), n, cyc + 1);
         @(posedge clk);
         #1;
      end
      for (int d = 0; d < DUMMY_NIB; d++) begin
         sio_in = 4'($urandom);
         if (d == DUMMY_NIB - 1) push_read(dev, int'(addr[MEM_AW-1:0]), n, cyc + 1);
         @(posedge clk);
         #1;
      end
      sio_in = 4'h0;
      for (int i = 0; i < 2 * n - 1; i++) begin
         @(posedge clk);
         #1;
      end
      deselect();
   endtask

`ifdef IDLI_QMEM_MODE_EN
   task automatic write_mode(input int dev, input logic [7:0] b);
      select_dev(dev);
      drive_nib(4'h0);
      drive_nib(4'h1);
      drive_nib(b[7:4]);
      drive_nib(b[3:0]);
      deselect();
      if (b[7:6] == 2'b11) ref_err = 1'b1;
      else                 ref_mode[dev] = int'(b[7:6]);
   endtask

   task automatic read_mode(input int dev);
      logic [3:0] hi;
      hi = 4'(ref_mode[dev] << 2);
      select_dev(dev);
      drive_nib(4'h0);
      sio_in = 4'h5;
      exp_q.push_back('{nib: hi, cyc: cyc + 1});
      exp_q.push_back('{nib: 4'h0, cyc: cyc + 2});
      @(posedge clk);
      #1;
      drive_nib(4'h0);
      deselect();
   endtask
`endif

   initial begin
      int          r_dev;
      int          r_len;
      logic [23:0] r_addr;

      rst    = 1'b1;
      cs_n   = '1;
      sio_in = 4'h0;
      for (int d = 0; d < NUM_DEV; d++) ref_mode[d] = 1;
      ref_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_output("reset_sio_oe", int'(sio_oe), 0);
      check_output("reset_sio_out", int'(sio_out), 0);
      check_output("reset_err", int'(err), 0);
      mon_en = 1'b1;

      $display("[TB] directed read/write and device isolation");
      wdata = '{8'h5A};
      apply_stimulus(1, 24'h000010);
      wdata = '{8'hA5, 8'h3C};
      apply_stimulus(0, 24'h000010);
      read_burst(0, 24'h000010, 2);
      read_burst(1, 24'h000010, 1);
      check_output("err_after_good_traffic", int'(err), int'(ref_err));

      $display("[TB] address wrap at top of device");
      wdata = '{8'h11, 8'h22};
      apply_stimulus(0, 24'h00FFFF);
      read_burst(0, 24'h000000, 1);
      read_burst(0, 24'hABFFFF, 2);

      $display("[TB] random bursts");
      for (int t = 0; t < 10; t++) begin
         r_dev  = $urandom_range(0, NUM_DEV - 1);
         r_len  = $urandom_range(1, 4);
         r_addr = {8'($urandom), 16'($urandom_range(16'h0100, 16'hFF00))};
         wdata.delete();
         for (int i = 0; i < r_len; i++) wdata.push_back(8'($urandom));
         apply_stimulus(r_dev, r_addr);
         read_burst(r_dev, {8'($urandom), r_addr[15:0]}, r_len);
      end

      $display("[TB] deselect after half a byte");
      send_header(0, 8'h02, 24'h000010);
      drive_nib(4'hF);
      deselect();
      read_burst(0, 24'h000010, 1);
      check_output("err_after_partial_write", int'(err), int'(ref_err));

      $display("[TB] unknown command");
      select_dev(1);
      drive_nib(4'h7);
      drive_nib(4'hE);
      for (int i = 0; i < 6; i++) drive_nib(4'($urandom));
      ref_err = 1'b1;
      check_output("err_bad_cmd", int'(err), int'(ref_err));
      deselect();
      read_burst(0, 24'h000010, 2);
      check_output("err_sticky", int'(err), int'(ref_err));

      $display("[TB] reset clears err but keeps memory");
      do_reset();
      check_output("err_after_reset", int'(err), int'(ref_err));
      read_burst(0, 24'h000010, 1);

      $display("[TB] multiple selects");
      cs_n = '0;
      drive_nib(4'h0);
      drive_nib(4'h2);
      deselect();
      ref_err = 1'b1;
      check_output("err_multi_select", int'(err), int'(ref_err));
      read_burst(0, 24'h000010, 1);
      read_burst(1, 24'h000010, 1);

      $display("[TB] reset during a transfer");
      select_dev(0);
      drive_nib(4'h0);
      drive_nib(4'h3);
      drive_nib(4'h0);
      drive_nib(4'h0);
      do_reset();
      check_output("err_after_mid_reset", int'(err), int'(ref_err));
      read_burst(0, 24'h000010, 2);

`ifdef IDLI_QMEM_MODE_EN
      $display("[TB] access modes");
      wdata = '{8'h77};
      apply_stimulus(0, 24'h000000);
      wdata = '{8'h66};
      apply_stimulus(0, 24'h00001F);
      wdata = '{8'h99};
      apply_stimulus(0, 24'h000041);
      write_mode(0, 8'h80);
      read_burst(0, 24'h00001F, 2);
      read_mode(0);
      write_mode(0, 8'h00);
      wdata = '{8'h12, 8'h34};
      apply_stimulus(0, 24'h000040);
      read_burst(0, 24'h000040, 2);
      write_mode(0, 8'h40);
      read_burst(0, 24'h000040, 2);
      check_output("err_before_bad_mode", int'(err), int'(ref_err));
      write_mode(1, 8'hC0);
      check_output("err_bad_mode", int'(err), int'(ref_err));
      read_mode(1);
`endif

      repeat (4) @(posedge clk);
      #1;
      check_output("scoreboard_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
